// File: rtl/rvm_mig_bridge.sv
// Bridge from the rvm_core single-word memory port to the MIG DDR3 application port.
// Single request in flight; one line buffer serves repeat reads, writes go straight to DDR3.
module rvm_mig_bridge #(
    parameter int unsigned APP_DW     = 128,
    parameter int unsigned APP_AW     = 28,
    parameter int unsigned ADDR_SHIFT = 1,
    parameter logic [31:0] MEM_BYTES  = 32'h0800_0000,
    parameter int unsigned TIMEOUT    = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           mem_addr,
    input  logic [31:0]           mem_wdata,
    input  logic                  mem_c_en,
    input  logic                  mem_w_en,
    input  logic [3:0]            mem_b_en,
    output logic [31:0]           mem_rdata,
    output logic                  mem_stall,
    output logic                  mem_error,
    input  logic                  calib_complete,
    output logic [APP_AW-1:0]     app_addr,
    output logic [2:0]            app_cmd,
    output logic                  app_en,
    input  logic                  app_rdy,
    output logic [APP_DW-1:0]     app_wdf_data,
    output logic [APP_DW/8-1:0]   app_wdf_mask,
    output logic                  app_wdf_wren,
    output logic                  app_wdf_end,
    input  logic                  app_wdf_rdy,
    input  logic [APP_DW-1:0]     app_rd_data,
    input  logic                  app_rd_data_valid
);

    localparam int unsigned LANES   = APP_DW / 32;
    localparam int unsigned MW      = APP_DW / 8;
    localparam int unsigned LB      = $clog2(MW);
    localparam int unsigned LANE_W  = LB - 2;
    localparam int unsigned TAG_W   = 32 - LB;
    localparam int unsigned CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned TO_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
    localparam logic [31:0] LINE_MASK = ~((32'd1 << (LB - ADDR_SHIFT)) - 32'd1);
    localparam logic [2:0]  CMD_WR  = 3'b000;
    localparam logic [2:0]  CMD_RD  = 3'b001;

    typedef enum logic [2:0] {IDLE, RD_CMD, RD_WAIT, WR, RESP} state_t;

    state_t              state, state_nxt;
    logic [APP_DW-1:0]   buf_line;
    logic [TAG_W-1:0]    buf_tag;
    logic                buf_valid;
    logic [CNT_W-1:0]    cnt;

    logic [LANE_W-1:0]   lane;
    logic [LANE_W+4:0]   lane_bit;
    logic [TAG_W-1:0]    line;
    logic [31:0]         line_addr;
    logic                in_range;
    logic                hit;
    logic                timed_out;
    logic [31:0]         buf_word;
    logic [31:0]         rd_word;
    logic [APP_DW-1:0]   wdata_rep;
    logic [MW-1:0]       wmask;
    logic [APP_DW-1:0]   bit_en;

    logic                app_en_nxt, wren_nxt, error_nxt;
    logic [2:0]          cmd_nxt;
    logic [APP_AW-1:0]   addr_nxt;
    logic [APP_DW-1:0]   wdata_nxt;
    logic [MW-1:0]       wmask_nxt;
    logic [31:0]         rdata_nxt;
    logic                buf_load, buf_inval, buf_merge;

    assign lane      = mem_addr[LB-1:2];
    assign lane_bit  = {lane, 5'd0};
    assign line      = mem_addr[31:LB];
    assign line_addr = (mem_addr >> ADDR_SHIFT) & LINE_MASK;
    assign in_range  = mem_addr < MEM_BYTES;
    assign hit       = buf_valid && (buf_tag == line);
    assign timed_out = (TIMEOUT != 0) && (cnt == CNT_W'(TO_LAST));
    assign buf_word  = buf_line[lane_bit +: 32];
    assign rd_word   = app_rd_data[lane_bit +: 32];
    assign wdata_rep = {LANES{mem_wdata}};

    assign mem_stall   = mem_c_en && (state != RESP);
    assign app_wdf_end = app_wdf_wren;

    // Byte mask: only the addressed lane may be written, and only its enabled bytes.
    always_comb begin
        wmask = '1;
        wmask[{lane, 2'b00} +: 4] = ~mem_b_en;
        bit_en = '0;
        for (int i = 0; i < MW; i++) begin
            bit_en[8*i +: 8] = {8{~wmask[i]}};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            app_en       <= 1'b0;
            app_wdf_wren <= 1'b0;
            app_cmd      <= CMD_WR;
            app_addr     <= '0;
            app_wdf_data <= '0;
            app_wdf_mask <= '1;
            mem_rdata    <= '0;
            mem_error    <= 1'b0;
        end else begin
            state        <= state_nxt;
            app_en       <= app_en_nxt;
            app_wdf_wren <= wren_nxt;
            app_cmd      <= cmd_nxt;
            app_addr     <= addr_nxt;
            app_wdf_data <= wdata_nxt;
            app_wdf_mask <= wmask_nxt;
            mem_rdata    <= rdata_nxt;
            mem_error    <= error_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (mem_c_en && calib_complete) begin
                    if (!in_range || (!mem_w_en && hit)) state_nxt = RESP;
                    else if (mem_w_en)                   state_nxt = WR;
                    else                                 state_nxt = RD_CMD;
                end
            end
            RD_CMD:  if (app_rdy) state_nxt = app_rd_data_valid ? RESP : RD_WAIT;
            RD_WAIT: if (app_rd_data_valid || timed_out) state_nxt = RESP;
            // Command and data channels complete independently; leave once both are done.
            WR: begin
                if (!(app_en && !app_rdy) && !(app_wdf_wren && !app_wdf_rdy)) state_nxt = RESP;
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        app_en_nxt = app_en;
        wren_nxt   = app_wdf_wren;
        cmd_nxt    = app_cmd;
        addr_nxt   = app_addr;
        wdata_nxt  = app_wdf_data;
        wmask_nxt  = app_wdf_mask;
        rdata_nxt  = mem_rdata;
        error_nxt  = 1'b0;
        buf_load   = 1'b0;
        buf_inval  = 1'b0;
        buf_merge  = 1'b0;
        case (state)
            IDLE: begin
                if (mem_c_en && calib_complete) begin
                    if (!in_range) begin
                        error_nxt = 1'b1;
                    end else if (!mem_w_en && hit) begin
                        rdata_nxt = buf_word;
                    end else if (!mem_w_en) begin
                        app_en_nxt = 1'b1;
                        cmd_nxt    = CMD_RD;
                        addr_nxt   = APP_AW'(line_addr);
                    end else begin
                        app_en_nxt = 1'b1;
                        wren_nxt   = 1'b1;
                        cmd_nxt    = CMD_WR;
                        addr_nxt   = APP_AW'(line_addr);
                        wdata_nxt  = wdata_rep;
                        wmask_nxt  = wmask;
                        buf_merge  = hit;
                    end
                end
            end
            RD_CMD: begin
                if (app_rdy) begin
                    app_en_nxt = 1'b0;
                    if (app_rd_data_valid) begin
                        buf_load  = 1'b1;
                        rdata_nxt = rd_word;
                    end
                end
            end
            RD_WAIT: begin
                if (app_rd_data_valid) begin
                    buf_load  = 1'b1;
                    rdata_nxt = rd_word;
                end else if (timed_out) begin
                    error_nxt = 1'b1;
                    buf_inval = 1'b1;
                end
            end
            WR: begin
                app_en_nxt = app_en && !app_rdy;
                wren_nxt   = app_wdf_wren && !app_wdf_rdy;
            end
            default: ;
        endcase
    end

    // Line buffer and read-wait cycle counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_line  <= '0;
            buf_tag   <= '0;
            buf_valid <= 1'b0;
            cnt       <= '0;
        end else begin
            if (buf_load) begin
                buf_line  <= app_rd_data;
                buf_tag   <= line;
                buf_valid <= 1'b1;
            end else if (buf_inval) begin
                buf_valid <= 1'b0;
            end else if (buf_merge) begin
                buf_line <= (buf_line & ~bit_en) | (wdata_rep & bit_en);
            end
            cnt <= (state == RD_WAIT && !app_rd_data_valid) ? cnt + CNT_W'(1) : '0;
        end
    end

endmodule

// File: tb/tb_rvm_mig_bridge.sv
// Self-checking bench for rvm_mig_bridge: behavioural MIG model, word-level reference memory,
// response scoreboard, vector table plus hand sequences for calibration, timeout and reset.
module tb_rvm_mig_bridge;

    localparam int unsigned TO   = 16;
    localparam logic [31:0] MEMB = 32'h0800_0000;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  mem_addr, mem_wdata, mem_rdata;
    logic         mem_c_en, mem_w_en, mem_stall, mem_error;
    logic [3:0]   mem_b_en;
    logic         calib_complete;
    logic [27:0]  app_addr;
    logic [2:0]   app_cmd;
    logic         app_en, app_rdy = 1'b0;
    logic [127:0] app_wdf_data;
    logic [15:0]  app_wdf_mask;
    logic         app_wdf_wren, app_wdf_end, app_wdf_rdy = 1'b0;
    logic [127:0] app_rd_data = '0;
    logic         app_rd_data_valid = 1'b0;

    always #5 clk = ~clk;

    rvm_mig_bridge #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_c_en(mem_c_en), .mem_w_en(mem_w_en),
        .mem_b_en(mem_b_en), .mem_rdata(mem_rdata), .mem_stall(mem_stall), .mem_error(mem_error),
        .calib_complete(calib_complete),
        .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
        .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask), .app_wdf_wren(app_wdf_wren),
        .app_wdf_end(app_wdf_end), .app_wdf_rdy(app_wdf_rdy),
        .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid)
    );

    typedef struct { logic [31:0] rdata; logic err; logic rd; } exp_t;
    typedef struct {
        logic we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] ben;
        int rdy_dly; int wdf_dly; int rd_lat; int exp_cmds; int exp_cycles;
    } vec_t;

    exp_t  sb[$];
    vec_t  vecs[13];
    int    checks = 0;
    int    errors = 0;

    // MIG model state
    int           rdy_dly = 0, wdf_dly = 0, rd_lat = 1;
    int           en_age = 0, wr_age = 0, rd_cnt = 0;
    logic [27:0]  rd_addr = '0;
    int           n_cmds = 0, n_wdf = 0;
    logic [27:0]  last_waddr = '0;
    logic [15:0]  last_wmask = '0;
    logic [127:0] last_wdata = '0;
    logic [127:0] wl;
    logic [127:0] mig_mem [logic [27:0]];
    logic [31:0]  ref_mem [logic [31:0]];

    // Current request bookkeeping
    logic         cur_we;
    logic [31:0]  cur_addr, cur_wdata;
    logic [3:0]   cur_ben;
    int           cmds0, wdf0;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        if (a[31:4] == 28'h10) begin
            case (a[3:2])
                2'd0: return 32'h0000_AAAA;
                2'd1: return 32'h0000_BBBB;
                2'd2: return 32'h0000_CCCC;
                default: return 32'h0000_DDDD;
            endcase
        end
        return {16'hC0DE, a[15:0]};
    endfunction

    function automatic logic [127:0] mig_line(input logic [27:0] la);
        logic [127:0] l;
        logic [31:0]  base;
        if (mig_mem.exists(la)) return mig_mem[la];
        base = {3'b000, la, 1'b0};
        for (int i = 0; i < 4; i++) l[32*i +: 32] = init_word(base + 32'(4*i));
        return l;
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_word(a);
    endfunction

    function automatic logic [15:0] exp_mask(input logic [31:0] a, input logic [3:0] ben);
        logic [15:0] m;
        int ln;
        m  = '1;
        ln = int'(a[3:2]);
        for (int b = 0; b < 4; b++) m[4*ln + b] = ~ben[b];
        return m;
    endfunction

    function automatic logic [27:0] exp_aaddr(input logic [31:0] a);
        logic [31:0] t;
        t = (a >> 1) & ~32'h7;
        return t[27:0];
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // MIG handshake drivers, updated away from the active edge
    always @(negedge clk) begin
        app_rd_data_valid = 1'b0;
        if (app_en) begin en_age++; app_rdy = (en_age > rdy_dly); end
        else begin en_age = 0; app_rdy = 1'b0; end
        if (app_wdf_wren) begin wr_age++; app_wdf_rdy = (wr_age > wdf_dly); end
        else begin wr_age = 0; app_wdf_rdy = 1'b0; end
        if (rd_cnt > 0) begin
            rd_cnt--;
            if (rd_cnt == 0) begin
                app_rd_data_valid = 1'b1;
                app_rd_data       = mig_line(rd_addr);
            end
        end else if (app_en && app_rdy && app_cmd == 3'b001 && rd_lat == 0) begin
            app_rd_data_valid = 1'b1;
            app_rd_data       = mig_line(app_addr);
        end
    end

    // MIG acceptance: commands, read scheduling, write data into the model memory
    always @(posedge clk) begin
        if (app_en && app_rdy) begin
            n_cmds++;
            if (app_cmd == 3'b001 && rd_lat > 0) begin
                rd_cnt  = rd_lat;
                rd_addr = app_addr;
            end
            if (app_cmd == 3'b000) last_waddr = app_addr;
        end
        if (app_wdf_wren && app_wdf_rdy) begin
            n_wdf++;
            last_wmask = app_wdf_mask;
            last_wdata = app_wdf_data;
            wl = mig_line(app_addr);
            for (int i = 0; i < 16; i++) if (!app_wdf_mask[i]) wl[8*i +: 8] = app_wdf_data[8*i +: 8];
            mig_mem[app_addr] = wl;
        end
    end

    task automatic start_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] ben, input logic force_err);
        exp_t e;
        logic [31:0] w;
        e.rd    = !we;
        e.err   = force_err || (addr >= MEMB);
        e.rdata = ref_read(addr);
        if (we && !e.err) begin
            w = ref_read(addr);
            for (int b = 0; b < 4; b++) if (ben[b]) w[8*b +: 8] = wdata[8*b +: 8];
            ref_mem[addr] = w;
        end
        sb.push_back(e);
        cur_we = we; cur_addr = addr; cur_wdata = wdata; cur_ben = ben;
        cmds0 = n_cmds; wdf0 = n_wdf;
        mem_addr = addr; mem_wdata = wdata; mem_b_en = ben; mem_w_en = we; mem_c_en = 1'b1;
    endtask

    task automatic wait_resp(input string name, input int exp_cmds, input int exp_cycles);
        int   cyc;
        exp_t e;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (mem_stall && cyc < 200);
        check({name, " stall_released"}, mem_stall, 1'b0);
        e = sb.pop_front();
        check({name, " error"}, mem_error, e.err);
        if (e.rd && !e.err) check({name, " rdata"}, mem_rdata, e.rdata);
        check({name, " mig_cmds"}, n_cmds - cmds0, exp_cmds);
        check({name, " stall_cycles"}, cyc, exp_cycles);
        if (cur_we && exp_cmds > 0) begin
            check({name, " wdf_beats"}, n_wdf - wdf0, 1);
            check({name, " wdf_mask"}, last_wmask, exp_mask(cur_addr, cur_ben));
            check({name, " app_addr"}, last_waddr, exp_aaddr(cur_addr));
            check({name, " wdf_data"}, last_wdata, {4{cur_wdata}});
        end
        mem_c_en = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        exp_t dropped;
        logic hold_ok;
        //            we    addr           wdata          ben   rdy wdf lat cmds cyc
        vecs[0]  = '{1'b0, 32'h0000_0200, 32'h0,         4'h0, 0,  0,  1,  1,   3};
        vecs[1]  = '{1'b0, 32'h0000_0104, 32'h0,         4'h0, 1,  0,  2,  1,   5};
        vecs[2]  = '{1'b0, 32'h0000_0104, 32'h0,         4'h0, 0,  0,  1,  0,   1};
        vecs[3]  = '{1'b0, 32'h0000_010C, 32'h0,         4'h0, 0,  0,  1,  0,   1};
        vecs[4]  = '{1'b1, 32'h0000_0108, 32'h1234_5678, 4'h3, 3,  0,  1,  1,   5};
        vecs[5]  = '{1'b0, 32'h0000_0108, 32'h0,         4'h0, 0,  0,  1,  0,   1};
        vecs[6]  = '{1'b1, 32'h0000_020C, 32'hDEAD_BEEF, 4'hF, 0,  2,  1,  1,   4};
        vecs[7]  = '{1'b0, 32'h0000_020C, 32'h0,         4'h0, 0,  0,  0,  1,   2};
        vecs[8]  = '{1'b0, 32'h0800_0000, 32'h0,         4'h0, 0,  0,  1,  0,   1};
        vecs[9]  = '{1'b0, 32'h07FF_FFFC, 32'h0,         4'h0, 2,  0,  3,  1,   7};
        vecs[10] = '{1'b1, 32'h0800_0010, 32'h5555_5555, 4'hF, 0,  0,  1,  0,   1};
        vecs[11] = '{1'b1, 32'h07FF_FFF0, 32'hAB00_0000, 4'h8, 1,  1,  1,  1,   3};
        vecs[12] = '{1'b0, 32'h07FF_FFF0, 32'h0,         4'h0, 0,  0,  1,  0,   1};

        rst = 1'b1; calib_complete = 1'b0;
        mem_addr = '0; mem_wdata = '0; mem_c_en = 1'b0; mem_w_en = 1'b0; mem_b_en = '0;
        repeat (3) @(negedge clk);
        check("reset app_en", app_en, 1'b0);
        check("reset wdf_wren", {app_wdf_wren, app_wdf_end}, 2'b00);
        check("reset stall", mem_stall, 1'b0);
        check("reset error", mem_error, 1'b0);
        check("reset rdata", mem_rdata, 32'h0);
        rst = 1'b0;

        // Calibration not complete: the core stalls and no MIG traffic is issued
        @(negedge clk);
        rdy_dly = 0; wdf_dly = 0; rd_lat = 1;
        start_req(1'b0, 32'h0000_0100, 32'h0, 4'h0, 1'b0);
        hold_ok = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (!mem_stall || app_en) hold_ok = 1'b0;
        end
        check("calib stall_hold", hold_ok, 1'b1);
        check("calib no_cmd", n_cmds - cmds0, 0);
        calib_complete = 1'b1;
        wait_resp("calib_read", 1, 3);

        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            rdy_dly = vecs[i].rdy_dly; wdf_dly = vecs[i].wdf_dly; rd_lat = vecs[i].rd_lat;
            start_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].ben, 1'b0);
            wait_resp($sformatf("vec%0d", i), vecs[i].exp_cmds, vecs[i].exp_cycles);
        end

        // Read timeout, then a late data beat that must not fill the buffer
        @(negedge clk);
        rdy_dly = 0; rd_lat = 40;
        start_req(1'b0, 32'h0000_0300, 32'h0, 4'h0, 1'b1);
        wait_resp("timeout", 1, 2 + TO);
        repeat (30) @(negedge clk);
        rd_lat = 1;
        start_req(1'b0, 32'h0000_0300, 32'h0, 4'h0, 1'b0);
        wait_resp("after_timeout", 1, 3);

        // Reset in RD_WAIT abandons the read; the stale beat afterwards is dropped
        @(negedge clk);
        rd_lat = 10;
        start_req(1'b0, 32'h0000_0400, 32'h0, 4'h0, 1'b0);
        repeat (4) @(negedge clk);
        check("pre_reset in_rd_wait", {mem_stall, app_en}, 2'b10);
        rst = 1'b1; mem_c_en = 1'b0;
        @(negedge clk);
        check("midreset app_en", app_en, 1'b0);
        check("midreset wdf_wren", app_wdf_wren, 1'b0);
        check("midreset stall", mem_stall, 1'b0);
        check("midreset error", mem_error, 1'b0);
        check("midreset rdata", mem_rdata, 32'h0);
        rst = 1'b0;
        dropped = sb.pop_front();
        repeat (15) @(negedge clk);
        rd_lat = 1;
        start_req(1'b0, 32'h0000_0404, 32'h0, 4'h0, 1'b0);
        wait_resp("after_reset", 1, 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
